// File: rtl/axis_dm_cmd_splitter.sv
// Splits upstream DataMover commands into chunks that stay inside C_MAX_BTT-aligned windows and
// merges the chunk statuses into one upstream status. Optional: AXIS_DM_CMD_SPLITTER_TAG_CHECK_EN.
module axis_dm_cmd_splitter #(
  parameter int unsigned C_M_AXIS_CMD_DATA_WIDTH = 73,
  parameter int unsigned C_M_AXIS_STS_DATA_WIDTH = 8,
  parameter int unsigned C_MAX_BTT               = 4096
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // Upstream command
  input  logic                               S_AXIS_CMD_TVALID,
  output logic                               S_AXIS_CMD_TREADY,
  input  logic [C_M_AXIS_CMD_DATA_WIDTH-1:0] S_AXIS_CMD_TDATA,
  // Merged status to upstream
  output logic                               M_AXIS_STS_TVALID,
  input  logic                               M_AXIS_STS_TREADY,
  output logic [C_M_AXIS_STS_DATA_WIDTH-1:0] M_AXIS_STS_TDATA,
  // Chunk command to DataMover
  output logic                               M_AXIS_CMD_TVALID,
  input  logic                               M_AXIS_CMD_TREADY,
  output logic [C_M_AXIS_CMD_DATA_WIDTH-1:0] M_AXIS_CMD_TDATA,
  // Chunk status from DataMover
  input  logic                               S_AXIS_STS_TVALID,
  output logic                               S_AXIS_STS_TREADY,
  input  logic [C_M_AXIS_STS_DATA_WIDTH-1:0] S_AXIS_STS_TDATA,
  output logic [31:0]                        debug
);

  localparam int unsigned OffW = $clog2(C_MAX_BTT);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCmd    = 2'd1,
    StSts    = 2'd2,
    StReport = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [22:0] rem_q;
  logic [3:0]  tag_q;
  logic        eof_q;
  logic        dre_req_q;
  logic [5:0]  dre_align_q;
  logic [2:0]  acc_q;
  logic        notok_q;
  logic [15:0] count_q;

  logic        s_cmd_ready_q;
  logic        m_cmd_valid_q;
  logic [72:0] m_cmd_data_q;
  logic        s_sts_ready_q;
  logic        m_sts_valid_q;
  logic [7:0]  m_sts_data_q;

  // Upstream command fields
  logic [3:0]  in_tag;
  logic [31:0] in_addr;
  logic        in_dre_req;
  logic        in_eof;
  logic [5:0]  in_dre_align;
  logic [22:0] in_btt;

  assign in_tag       = S_AXIS_CMD_TDATA[67:64];
  assign in_addr      = S_AXIS_CMD_TDATA[63:32];
  assign in_dre_req   = S_AXIS_CMD_TDATA[31];
  assign in_eof       = S_AXIS_CMD_TDATA[30];
  assign in_dre_align = S_AXIS_CMD_TDATA[29:24];
  assign in_btt       = S_AXIS_CMD_TDATA[22:0];

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[72:68], S_AXIS_CMD_TDATA[23]};

  // Room left in the current window; after the first chunk the address is aligned, so this
  // yields a full C_MAX_BTT for every later chunk.
  function automatic logic [22:0] chunk_len(input logic [31:0] addr, input logic [22:0] rem);
    logic [22:0] room;
    room = 23'(C_MAX_BTT) - 23'(addr[OffW-1:0]);
    return (rem < room) ? rem : room;
  endfunction

  function automatic logic [72:0] chunk_word(input logic [31:0] addr, input logic [22:0] rem,
                                             input logic [3:0] tag, input logic eof,
                                             input logic dre_req, input logic [5:0] dre_align);
    logic [22:0] len;
    len = chunk_len(addr, rem);
    return {5'b0, tag, addr, dre_req, eof && (rem == len), dre_align, 1'b0, len};
  endfunction

  // Status merge for the chunk status currently on S_AXIS_STS
  logic [2:0] sts_acc_d;
  logic       sts_notok_d;

  always_comb begin
    sts_acc_d   = acc_q | S_AXIS_STS_TDATA[6:4];
    sts_notok_d = notok_q | ~S_AXIS_STS_TDATA[7];
`ifdef AXIS_DM_CMD_SPLITTER_TAG_CHECK_EN
    if (S_AXIS_STS_TDATA[3:0] != tag_q) begin
      sts_acc_d[0] = 1'b1;
    end
`endif
  end

`ifndef AXIS_DM_CMD_SPLITTER_TAG_CHECK_EN
  logic unused_sts_tag;
  assign unused_sts_tag = ^S_AXIS_STS_TDATA[3:0];
`endif

  logic [22:0] cur_len;
  assign cur_len = m_cmd_data_q[22:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      rem_q         <= '0;
      tag_q         <= '0;
      eof_q         <= 1'b0;
      dre_req_q     <= 1'b0;
      dre_align_q   <= '0;
      acc_q         <= '0;
      notok_q       <= 1'b0;
      count_q       <= '0;
      s_cmd_ready_q <= 1'b0;
      m_cmd_valid_q <= 1'b0;
      m_cmd_data_q  <= '0;
      s_sts_ready_q <= 1'b0;
      m_sts_valid_q <= 1'b0;
      m_sts_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          s_cmd_ready_q <= 1'b1;
          if (S_AXIS_CMD_TVALID && s_cmd_ready_q) begin
            s_cmd_ready_q <= 1'b0;
            addr_q        <= in_addr;
            rem_q         <= in_btt;
            tag_q         <= in_tag;
            eof_q         <= in_eof;
            dre_req_q     <= in_dre_req;
            dre_align_q   <= in_dre_align;
            acc_q         <= '0;
            notok_q       <= 1'b0;
            count_q       <= '0;
            if (in_btt != '0) begin
              state_q       <= StCmd;
              m_cmd_valid_q <= 1'b1;
              m_cmd_data_q  <= chunk_word(in_addr, in_btt, in_tag, in_eof, in_dre_req,
                                          in_dre_align);
            end else begin
              state_q       <= StReport;
              m_sts_valid_q <= 1'b1;
              m_sts_data_q  <= {4'b0001, in_tag};
            end
          end
        end
        StCmd: begin
          if (M_AXIS_CMD_TREADY && m_cmd_valid_q) begin
            m_cmd_valid_q <= 1'b0;
            s_sts_ready_q <= 1'b1;
            addr_q        <= addr_q + 32'(cur_len);
            rem_q         <= rem_q - cur_len;
            count_q       <= count_q + 16'd1;
            state_q       <= StSts;
          end
        end
        StSts: begin
          if (S_AXIS_STS_TVALID && s_sts_ready_q) begin
            s_sts_ready_q <= 1'b0;
            acc_q         <= sts_acc_d;
            notok_q       <= sts_notok_d;
            if (rem_q == '0) begin
              state_q       <= StReport;
              m_sts_valid_q <= 1'b1;
              m_sts_data_q  <= {~sts_notok_d && (sts_acc_d == '0), sts_acc_d, tag_q};
            end else begin
              state_q       <= StCmd;
              m_cmd_valid_q <= 1'b1;
              m_cmd_data_q  <= chunk_word(addr_q, rem_q, tag_q, eof_q, dre_req_q, dre_align_q);
            end
          end
        end
        StReport: begin
          if (M_AXIS_STS_TREADY && m_sts_valid_q) begin
            m_sts_valid_q <= 1'b0;
            s_cmd_ready_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign S_AXIS_CMD_TREADY = s_cmd_ready_q;
  assign M_AXIS_CMD_TVALID = m_cmd_valid_q;
  assign M_AXIS_CMD_TDATA  = m_cmd_data_q;
  assign S_AXIS_STS_TREADY = s_sts_ready_q;
  assign M_AXIS_STS_TVALID = m_sts_valid_q;
  assign M_AXIS_STS_TDATA  = m_sts_data_q;
  assign debug             = {14'b0, state_q, count_q};

endmodule
